// File: rtl/arm_mem_pkg.sv
// Shared types and constants for the external-SRAM data-memory path.
// Contents: FSM state enum, default base address, half-word select bits.
package arm_mem_pkg;

  typedef enum logic [1:0] {IDLE, LOW, HIGH, DONE} state_t;

  localparam logic [31:0] DEFAULT_BASE_ADDR = 32'd1024;

  // LSB of the SRAM half-word address: low or high half of a 32-bit word
  localparam logic HALF_LO = 1'b0;
  localparam logic HALF_HI = 1'b1;

endpackage

// File: rtl/sram_wait_counter.sv
// Wait-state counter for one SRAM access phase.
// Ports:
//   clk, rst  - clock, async active-high reset
//   clear     - force count to 0 (has priority over inc)
//   inc       - advance count by one
//   last      - count has reached WAIT_CYCLES (final cycle of the phase)
module sram_wait_counter #(
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic inc,
  output logic last
);

  logic [3:0] count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)        count <= '0;
    else if (clear) count <= '0;
    else if (inc)   count <= count + 4'd1;
  end

  assign last = (count == 4'(WAIT_CYCLES));

endmodule

// File: rtl/sram_controller.sv
// MEM-stage controller: turns one 32-bit load/store into two half-word
// accesses on an external 16-bit asynchronous SRAM, freezing the pipeline
// via `ready` until the access is complete.
// Ports:
//   clk, rst           - clock, async active-high reset
//   mem_r_en, mem_w_en - load / store request (write wins if both)
//   address, data      - byte address and store data
//   data_memory_out    - registered load result, valid from the DONE cycle
//   ready              - 0 freezes the pipeline
//   sram_addr, sram_dq_out, sram_dq_oe, sram_we_n - registered SRAM pins
//   sram_dq_in         - read data from the DQ pad
//   addr_err           - sticky out-of-range flag
// Optional feature: define RANGE_CHECK_EN to reject out-of-range addresses
// (no SRAM cycle, read returns 0, addr_err set). Undefined: addr_err = 0
// and addresses wrap by truncation.
module sram_controller
  import arm_mem_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = DEFAULT_BASE_ADDR,
  parameter int unsigned WAIT_CYCLES = 1,
  parameter int unsigned SRAM_AW     = 18
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               mem_r_en,
  input  logic               mem_w_en,
  input  logic [31:0]        address,
  input  logic [31:0]        data,
  output logic [31:0]        data_memory_out,
  output logic               ready,
  output logic [SRAM_AW-1:0] sram_addr,
  output logic [15:0]        sram_dq_out,
  output logic               sram_dq_oe,
  input  logic [15:0]        sram_dq_in,
  output logic               sram_we_n,
  output logic               addr_err
);

  state_t             state, state_nxt;
  logic               req, start, lo_done, hi_done, last, range_bad;
  logic [SRAM_AW-2:0] w_in, w_lat;
  logic               op_wr;
  logic [15:0]        wdata_hi, rd_lo;

  assign req  = mem_r_en | mem_w_en;
  // Word index; address[1:0] drops out with the shift, high bits truncate.
  assign w_in = (SRAM_AW-1)'((address - BASE_ADDR) >> 2);

`ifdef RANGE_CHECK_EN
  assign range_bad = (address < BASE_ADDR) ||
                     (((address - BASE_ADDR) >> 2) >= (32'd1 << (SRAM_AW-1)));

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                    addr_err <= 1'b0;
    else if (start && range_bad) addr_err <= 1'b1;
  end
`else
  assign range_bad = 1'b0;
  assign addr_err  = 1'b0;
`endif

  sram_wait_counter #(.WAIT_CYCLES(WAIT_CYCLES)) u_wait (
    .clk  (clk),
    .rst  (rst),
    .clear(!(state == LOW || state == HIGH) || last),
    .inc  (1'b1),
    .last (last)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    start     = 1'b0;
    lo_done   = 1'b0;
    hi_done   = 1'b0;
    case (state)
      IDLE: if (req) begin
        start     = 1'b1;
        state_nxt = range_bad ? DONE : LOW;
      end
      LOW: if (last) begin
        lo_done   = 1'b1;
        state_nxt = HIGH;
      end
      HIGH: if (last) begin
        hi_done   = 1'b1;
        state_nxt = DONE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign ready = !(req && state != DONE);

  // SRAM pins are loaded one edge ahead of each phase so they are stable
  // (and glitch-free) for every cycle of that phase.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_wr           <= 1'b0;
      w_lat           <= '0;
      wdata_hi        <= '0;
      rd_lo           <= '0;
      data_memory_out <= '0;
      sram_addr       <= '0;
      sram_dq_out     <= '0;
      sram_dq_oe      <= 1'b0;
      sram_we_n       <= 1'b1;
    end else begin
      if (start) begin
        op_wr    <= mem_w_en;
        w_lat    <= w_in;
        wdata_hi <= data[31:16];
        if (range_bad) begin
          if (!mem_w_en) data_memory_out <= '0;
        end else begin
          sram_addr   <= {w_in, HALF_LO};
          sram_dq_out <= data[15:0];
          sram_dq_oe  <= mem_w_en;
          sram_we_n   <= !mem_w_en;
        end
      end
      if (lo_done) begin
        if (!op_wr) rd_lo <= sram_dq_in;
        sram_addr   <= {w_lat, HALF_HI};
        sram_dq_out <= wdata_hi;
      end
      if (hi_done) begin
        sram_we_n  <= 1'b1;
        sram_dq_oe <= 1'b0;
        // result lands on entry to DONE
        if (!op_wr) data_memory_out <= {sram_dq_in, rd_lo};
      end
    end
  end

endmodule

// File: tb/tb_sram_controller.sv
module tb_sram_controller;
  import arm_mem_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        r_en, w_en, aux_req;
  logic [31:0] address, data;

  logic [31:0] dmo;
  logic        ready, oe, we_n, err;
  logic [17:0] saddr;
  logic [15:0] dq_out, dq_in;

  logic [31:0] dmo0, dmo3;
  logic        rdy0, rdy3, oe0, oe3, we0, we3, err0, err3;
  logic [17:0] sa0, sa3;
  logic [15:0] dqo0, dqo3;

  logic [15:0] mem [0:(1<<18)-1];

  int total = 0;
  int bad   = 0;

  typedef struct { logic [17:0] addr; logic [15:0] dq; } beat_t;
  typedef struct { int lowcnt; logic [31:0] dmo; } cmp_t;
  beat_t wq[$];
  cmp_t  cq[$];

  always #5 clk = ~clk;

  sram_controller #(.WAIT_CYCLES(1)) u1 (
    .clk(clk), .rst(rst), .mem_r_en(r_en), .mem_w_en(w_en),
    .address(address), .data(data), .data_memory_out(dmo), .ready(ready),
    .sram_addr(saddr), .sram_dq_out(dq_out), .sram_dq_oe(oe),
    .sram_dq_in(dq_in), .sram_we_n(we_n), .addr_err(err));

  sram_controller #(.WAIT_CYCLES(0)) u0 (
    .clk(clk), .rst(rst), .mem_r_en(1'b0), .mem_w_en(aux_req),
    .address(address), .data(data), .data_memory_out(dmo0), .ready(rdy0),
    .sram_addr(sa0), .sram_dq_out(dqo0), .sram_dq_oe(oe0),
    .sram_dq_in(16'h0), .sram_we_n(we0), .addr_err(err0));

  sram_controller #(.WAIT_CYCLES(3)) u3 (
    .clk(clk), .rst(rst), .mem_r_en(1'b0), .mem_w_en(aux_req),
    .address(address), .data(data), .data_memory_out(dmo3), .ready(rdy3),
    .sram_addr(sa3), .sram_dq_out(dqo3), .sram_dq_oe(oe3),
    .sram_dq_in(16'h0), .sram_we_n(we3), .addr_err(err3));

  // async SRAM model for the main instance
  assign dq_in = mem[saddr];
  always @(posedge clk) if (!we_n) mem[saddr] = dq_out;

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h exp=%h", nm, act, exp);
    end
  endtask

  task automatic push_wr(logic [31:0] a, logic [31:0] d, int nlo, int nhi);
    logic [16:0] w;
    w = 17'((a - 32'd1024) >> 2);
    for (int i = 0; i < nlo; i++) wq.push_back('{{w, 1'b0}, d[15:0]});
    for (int i = 0; i < nhi; i++) wq.push_back('{{w, 1'b1}, d[31:16]});
  endtask

  task automatic push_cmp(int lc, logic [31:0] d);
    cq.push_back('{lc, d});
  endtask

  // Issue one access, optionally moving the address mid-access, hold the
  // request until ready, then drop it.
  task automatic access(bit rd, bit wr, logic [31:0] a, logic [31:0] d, bit chg);
    bit ok = 1'b0;
    @(posedge clk); #1;
    r_en = rd; w_en = wr; address = a; data = d;
    if (chg) begin @(posedge clk); #1; address = 32'd2000; end
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (ready) begin ok = 1'b1; break; end
    end
    if (!ok) begin
      total++; bad++;
      $display("FAIL access_timeout addr=%h", a);
    end
    @(posedge clk); #1;
    r_en = 1'b0; w_en = 1'b0;
  endtask

  // Monitor: write beats and access completions against the scoreboard
  int lowcnt = 0;
  always @(negedge clk) begin
    if (rst) lowcnt = 0;
    else begin
      chk("oe_vs_we", {63'd0, oe}, {63'd0, ~we_n});
      if (!we_n) begin
        if (wq.size() == 0) begin
          total++; bad++;
          $display("FAIL beat_unexpected act=%h/%h exp=none", saddr, dq_out);
        end else begin
          beat_t b;
          b = wq.pop_front();
          chk("beat_addr", 64'(saddr), 64'(b.addr));
          chk("beat_dq", 64'(dq_out), 64'(b.dq));
        end
      end
      if (r_en | w_en) begin
        if (!ready) lowcnt++;
        else if (lowcnt > 0) begin
          if (cq.size() == 0) begin
            total++; bad++;
            $display("FAIL done_unexpected act=%0d exp=none", lowcnt);
          end else begin
            cmp_t c;
            c = cq.pop_front();
            chk("ready_low_cycles", 64'(lowcnt), 64'(c.lowcnt));
            chk("data_memory_out", 64'(dmo), 64'(c.dmo));
          end
          lowcnt = 0;
        end
      end
    end
  end

  initial begin
    int c0, c3, wc0, wc3;
    bit d0, d3;
    rst = 1'b1; r_en = 1'b0; w_en = 1'b0; aux_req = 1'b0;
    address = '0; data = '0;
    repeat (2) @(posedge clk); #1;
    chk("rst_dmo", 64'(dmo), 64'd0);
    chk("rst_we_n", 64'(we_n), 64'd1);
    chk("rst_oe", 64'(oe), 64'd0);
    chk("rst_addr", 64'(saddr), 64'd0);
    chk("rst_dq", 64'(dq_out), 64'd0);
    chk("rst_ready", 64'(ready), 64'd1);
    chk("rst_err", 64'(err), 64'd0);
    rst = 1'b0;

    // store then load back
    push_wr(32'd1028, 32'hDEADBEEF, 2, 2);
    push_cmp(5, 32'h0);
    access(0, 1, 32'd1028, 32'hDEADBEEF, 0);
    push_cmp(5, 32'hDEADBEEF);
    access(1, 0, 32'd1028, 32'h0, 0);

    // load of preloaded words
    mem[10] = 16'h1234; mem[11] = 16'h5678;
    push_cmp(5, 32'h56781234);
    access(1, 0, 32'd1044, 32'h0, 0);

    // read+write together is a write; address moved during LOW is ignored
    push_wr(32'd1032, 32'hCAFEF00D, 2, 2);
    push_cmp(5, 32'h56781234);
    access(1, 1, 32'd1032, 32'hCAFEF00D, 1);
    push_cmp(5, 32'hCAFEF00D);
    access(1, 0, 32'd1032, 32'h0, 0);

    // reset during the HIGH phase of a write
    push_wr(32'd1048, 32'h11112222, 2, 0);
    @(posedge clk); #1;
    w_en = 1'b1; address = 32'd1048; data = 32'h11112222;
    repeat (3) @(posedge clk); #1;
    rst = 1'b1; w_en = 1'b0;
    #1;
    chk("mid_rst_we_n", 64'(we_n), 64'd1);
    chk("mid_rst_oe", 64'(oe), 64'd0);
    chk("mid_rst_dmo", 64'(dmo), 64'd0);
    chk("mid_rst_addr", 64'(saddr), 64'd0);
    chk("mid_rst_state", 64'(u1.state), 64'(IDLE));
    repeat (2) @(posedge clk); #1;
    rst = 1'b0;
    push_cmp(5, 32'hDEADBEEF);
    access(1, 0, 32'd1028, 32'h0, 0);

`ifdef RANGE_CHECK_EN
    push_cmp(1, 32'h0);
    access(1, 0, 32'd512, 32'h0, 0);
    chk("range_err_set", 64'(err), 64'd1);
    push_cmp(5, 32'hDEADBEEF);
    access(1, 0, 32'd1028, 32'h0, 0);
    chk("range_err_sticky", 64'(err), 64'd1);
`else
    // 512-1024 wraps to word 0x1FF80 -> half-words 0x3FF00/0x3FF01
    mem[18'h3FF00] = 16'hAAAA; mem[18'h3FF01] = 16'h5555;
    push_cmp(5, 32'h5555AAAA);
    access(1, 0, 32'd512, 32'h0, 0);
    chk("err_tied_low", 64'(err), 64'd0);
`endif

    // wait-state sweep on the WAIT_CYCLES=0 and =3 instances
    @(posedge clk); #1;
    address = 32'd1100; data = 32'h0F0F0F0F; aux_req = 1'b1;
    c0 = 0; c3 = 0; wc0 = 0; wc3 = 0; d0 = 1'b0; d3 = 1'b0;
    for (int n = 0; n < 20 && !(d0 && d3); n++) begin
      @(negedge clk);
      if (!d0) begin
        if (!we0) wc0++;
        if (rdy0) d0 = 1'b1; else c0++;
      end
      if (!d3) begin
        if (!we3) wc3++;
        if (rdy3) d3 = 1'b1; else c3++;
      end
    end
    @(posedge clk); #1;
    aux_req = 1'b0;
    chk("w0_done", 64'(d0), 64'd1);
    chk("w3_done", 64'(d3), 64'd1);
    chk("w0_ready_low", 64'(c0), 64'd3);
    chk("w3_ready_low", 64'(c3), 64'd9);
    chk("w0_we_cycles", 64'(wc0), 64'd2);
    chk("w3_we_cycles", 64'(wc3), 64'd8);

    repeat (6) @(posedge clk);
    chk("beats_left", 64'(wq.size()), 64'd0);
    chk("dones_left", 64'(cq.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sram_controller.md
Name: sram_controller

Overview:
- MEM-stage initiator that turns single-cycle 32-bit pipeline loads/stores into multi-cycle accesses on an external 16-bit asynchronous SRAM.
- Drives the SRAM side of the memory interface. Holds the pipeline with a `ready` signal until each access completes.
- Sits between the MEM stage (alu_result / val_rm / mem_r_en / mem_w_en) and the board SRAM pins, in place of the on-chip data memory.

Parameters:
- BASE_ADDR, 1024, byte address mapped to SRAM word 0.
- WAIT_CYCLES, 1, extra cycles each half-word phase is held (0..15).
- SRAM_AW, 18, SRAM half-word address width.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- mem_r_en  input  1  load request from MEM stage.
- mem_w_en  input  1  store request from MEM stage.
- address  input  32  byte address (alu_result).
- data  input  32  store data (val_rm).
- data_memory_out  output  32  load result, registered.
- ready  output  1  0 = freeze pipeline; 1 = access done or no access pending.
- sram_addr  output  SRAM_AW  half-word address.
- sram_dq_out  output  16  write data to pad.
- sram_dq_oe  output  1  1 = controller drives the DQ pad.
- sram_dq_in  input  16  read data from pad.
- sram_we_n  output  1  active-low write strobe.
- addr_err  output  1  range error flag (only with RANGE_CHECK_EN; tied 0 otherwise).

Behaviour:
- Reset (async, any state): state=IDLE, wait counter=0, data_memory_out=0, sram_addr=0, sram_dq_out=0, sram_dq_oe=0, sram_we_n=1, addr_err=0.
- Word index: w = (address - BASE_ADDR) >> 2, 32-bit unsigned subtraction, truncated so that {w, 1'b0} fits SRAM_AW. Low half-word goes to sram_addr={w,0}; high half-word goes to sram_addr={w,1}. address[1:0] is ignored.
- FSM states: IDLE, LOW, HIGH, DONE.
  - IDLE: if mem_w_en|mem_r_en, latch op/w/data and go to LOW with counter=0. If both are asserted, the access is a write.
  - LOW: drive the low-half address. Count to WAIT_CYCLES. On the last cycle, a read captures sram_dq_in into rd_buf[15:0]. Then go to HIGH with counter=0.
  - HIGH: same as LOW for the high half. A read captures into rd_buf[31:16]. Then go to DONE.
  - DONE: for a read, data_memory_out <= rd_buf at the DONE->IDLE edge, so it is valid from the DONE cycle's end onward. Preferred alternative: the register updates on entry to DONE. Implement entry-update: data_memory_out is valid during the DONE cycle. Next state is IDLE unconditionally.
- Each phase lasts WAIT_CYCLES+1 cycles.
- ready = !((mem_r_en|mem_w_en) && state!=DONE). No request means ready=1.
- Request latency: the request cycle in IDLE plus 2*(WAIT_CYCLES+1) cycles have ready=0; ready=1 in DONE. With WAIT_CYCLES=1: 5 low cycles, then 1 high cycle.
- Writes: sram_dq_oe=1 and sram_we_n=0 for every cycle of LOW and HIGH. sram_dq_out = data[15:0] in LOW and data[31:16] in HIGH. sram_addr is stable for the whole phase. All SRAM outputs are registered (glitch-free).
- Reads: sram_dq_oe=0, sram_we_n=1 throughout.
- Request inputs are sampled only in IDLE. Deasserting or changing them mid-access has no effect; the latched access completes.
- A request still asserted in DONE is the pipeline's next instruction. It is seen in the following IDLE cycle, so there is exactly one DONE cycle between back-to-back accesses.
- data_memory_out holds its value across writes and idle cycles.

Optional Feature:
- RANGE_CHECK_EN defined: in IDLE, a request with address < BASE_ADDR, or w >= 2**(SRAM_AW-1), skips LOW/HIGH and goes straight to DONE.
  - No SRAM strobe is issued.
  - A read returns 0.
  - addr_err is set (sticky) until rst.
- RANGE_CHECK_EN undefined: no check, address wraps via truncation, addr_err is constant 0.

Decomposition:
- Package arm_mem_pkg holds:
  - the state enum (IDLE/LOW/HIGH/DONE);
  - the localparam DEFAULT_BASE_ADDR=1024;
  - the half-select constants HALF_LO=1'b0 and HALF_HI=1'b1.
- One sub-module, sram_wait_counter: load/clear, increment, and a `last` output when count==WAIT_CYCLES. It is reused by the future cache fill path.

Test Plan:
- Store: WAIT_CYCLES=1, mem_w_en=1, address=1028, data=32'hDEADBEEF → sram_addr=2 with dq_out=16'hBEEF and we_n=0 for 2 cycles, then sram_addr=3 with dq_out=16'hDEAD for 2 cycles; ready=0 for 5 cycles, then 1.
- Load: mem_r_en=1, address=1028, model returns 16'hBEEF at address 2 and 16'hDEAD at address 3 → data_memory_out=32'hDEADBEEF in the DONE cycle; we_n stays 1 and oe stays 0.
- Wait-state sweep: WAIT_CYCLES=0 and 3 → ready low for 3 and 9 cycles respectively.
- Simultaneous/mid-change: mem_r_en=mem_w_en=1 → a write occurs. Changing address to 2000 during LOW → the HIGH phase still uses the original w.
- Reset mid-access: assert rst during HIGH of a write → we_n=1, oe=0, state=IDLE and data_memory_out=0 immediately (async). A new load after release completes normally.
- RANGE_CHECK_EN: load at address=512 → no we_n/addr activity, data_memory_out=0, ready low exactly 1 cycle, addr_err=1 and it stays 1.
